// File: rtl/complex_mult_twiddle_w8_pipe.sv
// complex_mult_twiddle_w8_pipe: 3-stage pipelined multiply of a complex sample
// by W8^k = e^(-j*2*pi*k/8), with round half-up, saturation, valid/ready
// backpressure and a sideband tag.
// Optional macro TWIDDLE_CONJ_EN: adds in_conj to multiply by conj(W8^k) (IFFT).
module complex_mult_twiddle_w8_pipe #(
  parameter int DW    = 16,
  parameter int FRAC  = DW-1,
  parameter int TAG_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*DW-1:0]   in_data,
  input  logic [2:0]        in_k,
  input  logic [TAG_W-1:0]  in_tag,
`ifdef TWIDDLE_CONJ_EN
  input  logic              in_conj,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*DW-1:0]   out_data,
  output logic [TAG_W-1:0]  out_tag
);

  // Wide enough for (DW+1)-bit sum times a DW-bit constant plus negation headroom.
  localparam int PW = 2*DW+4;
  localparam real HALF_SQRT2 = 0.70710678118654752;
  localparam int C_INT = $rtoi(HALF_SQRT2 * real'(64'd1 << FRAC) + 0.5);
  localparam logic signed [PW-1:0] C    = PW'(C_INT);
  localparam logic signed [PW-1:0] RND  = PW'(1) << (FRAC-1);
  localparam logic signed [PW-1:0] MAXV = (PW'(1) << (DW-1)) - PW'(1);
  localparam logic signed [PW-1:0] MINV = -(PW'(1) << (DW-1));

  logic [3:1] vld_pipe;
  logic       adv;

  logic signed [DW-1:0] in_a, in_b;
  logic signed [DW:0]   in_s, in_d;
  logic [2:0]           k_eff;

  logic signed [DW-1:0] s1_a, s1_b;
  logic signed [DW:0]   s1_s, s1_d;
  logic [2:0]           s1_k;
  logic [TAG_W-1:0]     s1_tag;

  logic signed [PW-1:0] ash, bsh, sc, dc, n_re, n_im;
  logic signed [PW-1:0] s2_re, s2_im;
  logic [TAG_W-1:0]     s2_tag;

  logic signed [PW-1:0] r_re, r_im;

  // Whole pipe moves together; it can move whenever the last stage is empty or drained.
  assign adv       = !vld_pipe[3] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[3];

  // Stage 1 inputs: split components, form sign-extended sum/difference, resolve exponent.
  always_comb begin
    in_a = $signed(in_data[2*DW-1:DW]);
    in_b = $signed(in_data[DW-1:0]);
    in_s = {in_a[DW-1], in_a} + {in_b[DW-1], in_b};
    in_d = {in_a[DW-1], in_a} - {in_b[DW-1], in_b};
`ifdef TWIDDLE_CONJ_EN
    k_eff = in_conj ? (~in_k) + 3'd1 : in_k;
`else
    k_eff = in_k;
`endif
  end

  // Valid shift register; a bubble enters whenever no input transfer happens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else if (adv) vld_pipe <= {vld_pipe[2:1], in_valid};
  end

  // Stage 1 registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a <= '0; s1_b <= '0; s1_s <= '0; s1_d <= '0; s1_k <= '0; s1_tag <= '0;
    end else if (adv) begin
      s1_a <= in_a; s1_b <= in_b; s1_s <= in_s; s1_d <= in_d;
      s1_k <= k_eff; s1_tag <= in_tag;
    end
  end

  // Stage 2 datapath: odd k scale by C, even k shift to the same 2^FRAC scale.
  always_comb begin
    ash = PW'(s1_a) <<< FRAC;
    bsh = PW'(s1_b) <<< FRAC;
    sc  = PW'(s1_s) * C;
    dc  = PW'(s1_d) * C;
    case (s1_k)
      3'd0:    begin n_re = ash;  n_im = bsh;  end
      3'd1:    begin n_re = sc;   n_im = -dc;  end
      3'd2:    begin n_re = bsh;  n_im = -ash; end
      3'd3:    begin n_re = -dc;  n_im = -sc;  end
      3'd4:    begin n_re = -ash; n_im = -bsh; end
      3'd5:    begin n_re = -sc;  n_im = dc;   end
      3'd6:    begin n_re = -bsh; n_im = ash;  end
      default: begin n_re = dc;   n_im = sc;   end
    endcase
  end

  // Stage 2 registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_re <= '0; s2_im <= '0; s2_tag <= '0;
    end else if (adv) begin
      s2_re <= n_re; s2_im <= n_im; s2_tag <= s1_tag;
    end
  end

  function automatic logic [DW-1:0] sat(input logic signed [PW-1:0] v);
    if (v > MAXV)      return MAXV[DW-1:0];
    else if (v < MINV) return MINV[DW-1:0];
    else               return v[DW-1:0];
  endfunction

  // Stage 3 datapath: round half-up back to FRAC fractional bits.
  always_comb begin
    r_re = (s2_re + RND) >>> FRAC;
    r_im = (s2_im + RND) >>> FRAC;
  end

  // Stage 3 / output registers; hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0; out_tag <= '0;
    end else if (adv) begin
      out_data <= {sat(r_re), sat(r_im)};
      out_tag  <= s2_tag;
    end
  end

endmodule

// File: tb/tb_complex_mult_twiddle_w8_pipe.sv
// Directed self-checking bench for complex_mult_twiddle_w8_pipe (DW=16, FRAC=15).
module tb_complex_mult_twiddle_w8_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [2:0]  in_k = '0;
  logic [5:0]  in_tag = '0;
  logic        in_conj = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [5:0]  out_tag;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  complex_mult_twiddle_w8_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_k(in_k), .in_tag(in_tag),
`ifdef TWIDDLE_CONJ_EN
    .in_conj(in_conj),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
  );

  function automatic logic [31:0] pack(input int re, input int im);
    return {re[15:0], im[15:0]};
  endfunction

  // Drive one sample with out_ready=1, return first output and cycles until it appears.
  task automatic run_one(input int a, input int b, input logic [2:0] k, input logic [5:0] tag,
                         input logic conj, output logic [31:0] d, output logic [5:0] t, output int lat);
    @(negedge clk);
    in_data = pack(a, b); in_k = k; in_tag = tag; in_conj = conj; in_valid = 1'b1; out_ready = 1'b1;
    lat = 0; d = '0; t = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      in_valid = 1'b0; in_conj = 1'b0;
      if (out_valid) begin lat = c; d = out_data; t = out_tag; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_cmp++; if (out_tag !== 6'h0) begin n_bad++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_k1;
    logic [31:0] d; logic [5:0] t; int lat;
    run_one(16384, 0, 3'd1, 6'd37, 1'b0, d, t, lat);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL k1_latency: got %0d want 3", lat); end
    n_cmp++; if (d !== pack(11585, -11585)) begin n_bad++; $display("FAIL k1_data: got %h want %h", d, pack(11585, -11585)); end
    n_cmp++; if (t !== 6'd37) begin n_bad++; $display("FAIL k1_tag: got %0d want 37", t); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_d [4];
    int out_cyc [4];
    int sent = 0, got = 0;
    exp_d[0] = pack(100, -200); exp_d[1] = pack(-200, -100);
    exp_d[2] = pack(-100, 200); exp_d[3] = pack(200, 100);
    for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (sent < 4) begin
        in_valid = 1'b1; in_data = pack(100, -200); in_k = 3'(2*sent); in_tag = 6'(sent);
      end else in_valid = 1'b0;
      #1;
      if (out_valid && out_ready) begin
        out_cyc[got] = cyc;
        n_cmp++; if (out_data !== exp_d[got]) begin n_bad++; $display("FAIL b2b_data[%0d]: got %h want %h", got, out_data, exp_d[got]); end
        n_cmp++; if (out_tag !== 6'(got)) begin n_bad++; $display("FAIL b2b_tag[%0d]: got %0d want %0d", got, out_tag, got); end
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    n_cmp++; if (got !== 4) begin n_bad++; $display("FAIL b2b_count: got %0d want 4", got); end
    else begin
      n_cmp++; if (out_cyc[0] !== 3) begin n_bad++; $display("FAIL b2b_first_cycle: got %0d want 3", out_cyc[0]); end
      for (int i = 1; i < 4; i++) begin
        n_cmp++; if (out_cyc[i] !== out_cyc[0] + i) begin n_bad++; $display("FAIL b2b_consecutive[%0d]: got %0d want %0d", i, out_cyc[i], out_cyc[0] + i); end
      end
    end
  endtask

  task automatic test_saturation;
    logic [31:0] d; logic [5:0] t; int lat;
    run_one(-32768, 0, 3'd4, 6'd1, 1'b0, d, t, lat);
    n_cmp++; if (d !== pack(32767, 0)) begin n_bad++; $display("FAIL sat_k4_negmin: got %h want %h", d, pack(32767, 0)); end
    run_one(32767, 32767, 3'd3, 6'd2, 1'b0, d, t, lat);
    n_cmp++; if (d !== pack(0, -32768)) begin n_bad++; $display("FAIL sat_k3_min: got %h want %h", d, pack(0, -32768)); end
    run_one(32767, 32767, 3'd7, 6'd3, 1'b0, d, t, lat);
    n_cmp++; if (d !== pack(0, 32767)) begin n_bad++; $display("FAIL sat_k7_max: got %h want %h", d, pack(0, 32767)); end
    run_one(0, -32768, 3'd6, 6'd4, 1'b0, d, t, lat);
    n_cmp++; if (d !== pack(32767, 0)) begin n_bad++; $display("FAIL sat_k6_negmin: got %h want %h", d, pack(32767, 0)); end
  endtask

  task automatic test_rounding;
    logic [31:0] d; logic [5:0] t; int lat;
    run_one(3, 0, 3'd1, 6'd5, 1'b0, d, t, lat);
    n_cmp++; if (d !== pack(2, -2)) begin n_bad++; $display("FAIL round_k1: got %h want %h", d, pack(2, -2)); end
    run_one(3, 0, 3'd5, 6'd6, 1'b0, d, t, lat);
    n_cmp++; if (d !== pack(-2, 2)) begin n_bad++; $display("FAIL round_k5: got %h want %h", d, pack(-2, 2)); end
    run_one(1, 0, 3'd1, 6'd7, 1'b0, d, t, lat);
    n_cmp++; if (d !== pack(1, -1)) begin n_bad++; $display("FAIL round_k1_small: got %h want %h", d, pack(1, -1)); end
  endtask

  // Sample i: a=100*(i+1), b=-(37*i+5), k alternates 0/2.
  task automatic test_stall;
    int sent = 0, got = 0, a, b;
    logic [31:0] held = '0, exp_d;
    logic held_v = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 6 && cyc < 11);
      if (sent < 8) begin
        in_valid = 1'b1; in_data = pack(100*(sent+1), -(37*sent+5));
        in_k = (sent % 2 == 1) ? 3'd2 : 3'd0; in_tag = 6'(sent + 16);
      end else in_valid = 1'b0;
      #1;
      if (held_v) begin
        n_cmp++; if (out_data !== held) begin n_bad++; $display("FAIL stall_hold_data: got %h want %h", out_data, held); end
      end
      if (out_valid && !out_ready) begin
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
      end
      held_v = out_valid && !out_ready; held = out_data;
      if (out_valid && out_ready) begin
        a = 100*(got+1); b = -(37*got+5);
        exp_d = (got % 2 == 1) ? pack(b, -a) : pack(a, b);
        n_cmp++; if (out_data !== exp_d) begin n_bad++; $display("FAIL stall_data[%0d]: got %h want %h", got, out_data, exp_d); end
        n_cmp++; if (out_tag !== 6'(got + 16)) begin n_bad++; $display("FAIL stall_tag[%0d]: got %0d want %0d", got, out_tag, got + 16); end
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++; if (got !== 8) begin n_bad++; $display("FAIL stall_count: got %0d want 8", got); end
    repeat (4) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_no_dup: got out_valid %b want 0", out_valid); end
  endtask

`ifdef TWIDDLE_CONJ_EN
  task automatic test_conj;
    logic [31:0] d; logic [5:0] t; int lat;
    run_one(16384, 0, 3'd1, 6'd9, 1'b1, d, t, lat);
    n_cmp++; if (d !== pack(11585, 11585)) begin n_bad++; $display("FAIL conj_k1: got %h want %h", d, pack(11585, 11585)); end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL conj_latency: got %0d want 3", lat); end
  endtask
`endif

  task automatic test_reset_inflight;
    int seen = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      in_valid = (cyc < 3); in_data = pack(500, 600); in_k = 3'd0; in_tag = 6'(cyc + 40);
    end
    #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rst_pre_valid: got %b want 1", out_valid); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_async_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL rst_async_data: got %h want 0", out_data); end
    n_cmp++; if (out_tag !== 6'h0) begin n_bad++; $display("FAIL rst_async_tag: got %h want 0", out_tag); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rst_no_replay: got %0d outputs want 0", seen); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_k1();
    test_back_to_back();
    test_saturation();
    test_rounding();
    test_stall();
`ifdef TWIDDLE_CONJ_EN
    test_conj();
`endif
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
